// File: rtl/core_pkg.sv
// Shared core definitions used by the register-hazard scoreboard.
// Register address width, register count, scoreboard counter type and a
// small helper that decides whether an operand names a trackable register.
package core_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int NUM_REGS        = 32;
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [SB_CNT_W-1:0]   sb_cnt_t;

  // x0 is hard-wired to zero, so it never carries a dependency.
  function automatic logic reg_tracked(input logic use_b, input reg_addr_t addr);
    return use_b && (addr != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: per-register saturating up/down counter of pending writes.
// inc and dec together leave the count unchanged; clr wins over both.
// underflow_o flags a dec while the count is already zero.
module sb_entry #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             resetn_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             at_max_s;
  logic             at_zero_s;

  assign at_max_s    = (cnt_r == CNT_W'(MAX_INFLIGHT));
  assign at_zero_s   = (cnt_r == {CNT_W{1'b0}});
  assign underflow_o = dec && at_zero_s;
  assign cnt_o       = cnt_r;

  // Next count: clear, saturating increment, guarded decrement, or hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (inc && !dec) begin
      if (at_max_s) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      if (at_zero_s) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes between the ID->EX
// handoff and the WB register-file write, and stalls ID on RAW hazards or
// when another write to a destination would overflow its counter.
// Optional build macro HAZARD_WB_BYPASS_EN: lets a RAW hazard clear in the
// WB cycle itself when that WB write retires the last pending write
// (the register file writes through).
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int BITSIZE      = 32,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               ID_chk_valid_i,
  input  logic [4:0]         ID_chk_rs1_i,
  input  logic               ID_chk_rs1_use_i,
  input  logic [4:0]         ID_chk_rs2_i,
  input  logic               ID_chk_rs2_use_i,
  input  logic [4:0]         ID_chk_rd_i,
  input  logic               ID_chk_rd_use_i,
  input  logic               ID_issue_i,
  input  logic               WB_retire_i,
  input  logic [4:0]         WB_retire_rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [31:0]        busy_o,
  output logic               err_o,
  output logic [BITSIZE-1:0] stall_cnt_o
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [CNT_W-1:0]   cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;
  logic [NUM_REGS-1:0] uf_s;
  logic [NUM_REGS-1:0] busy_s;
  logic               issue_wr_s;
  logic               retire_wr_s;
  logic               raw1_s;
  logic               raw2_s;
  logic               ovf_s;
  logic               byp1_s;
  logic               byp2_s;
  logic               stall_s;
  logic               err_r;
  logic [BITSIZE-1:0] stall_cnt_r;

  assign issue_wr_s  = ID_issue_i && reg_tracked(ID_chk_rd_use_i, ID_chk_rd_i);
  assign retire_wr_s = reg_tracked(WB_retire_i, WB_retire_rd_i);

  // x0 has no counter; it reads as permanently idle.
  assign cnt_s[0]  = {CNT_W{1'b0}};
  assign uf_s[0]   = 1'b0;
  assign inc_s[0]  = 1'b0;
  assign dec_s[0]  = 1'b0;
  assign busy_s[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      assign inc_s[r]  = issue_wr_s  && (ID_chk_rd_i    == reg_addr_t'(r));
      assign dec_s[r]  = retire_wr_s && (WB_retire_rd_i == reg_addr_t'(r));
      assign busy_s[r] = (cnt_s[r] != {CNT_W{1'b0}});

      sb_entry #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
      ) u_entry (
        .clk         (clk),
        .resetn_i    (resetn_i),
        .inc         (inc_s[r]),
        .dec         (dec_s[r]),
        .clr         (flush_i),
        .cnt_o       (cnt_s[r]),
        .underflow_o (uf_s[r])
      );
    end
  endgenerate

`ifdef HAZARD_WB_BYPASS_EN
  assign byp1_s = WB_retire_i && (WB_retire_rd_i == ID_chk_rs1_i) &&
                  (cnt_s[ID_chk_rs1_i] == CNT_W'(1));
  assign byp2_s = WB_retire_i && (WB_retire_rd_i == ID_chk_rs2_i) &&
                  (cnt_s[ID_chk_rs2_i] == CNT_W'(1));
`else
  assign byp1_s = 1'b0;
  assign byp2_s = 1'b0;
`endif

  assign raw1_s = reg_tracked(ID_chk_rs1_use_i, ID_chk_rs1_i) &&
                  (cnt_s[ID_chk_rs1_i] != {CNT_W{1'b0}}) && !byp1_s;
  assign raw2_s = reg_tracked(ID_chk_rs2_use_i, ID_chk_rs2_i) &&
                  (cnt_s[ID_chk_rs2_i] != {CNT_W{1'b0}}) && !byp2_s;
  assign ovf_s  = reg_tracked(ID_chk_rd_use_i, ID_chk_rd_i) &&
                  (cnt_s[ID_chk_rd_i] == CNT_W'(MAX_INFLIGHT));

  assign stall_s     = ID_chk_valid_i && (raw1_s || raw2_s || ovf_s);
  assign stall_o     = stall_s;
  assign busy_o      = busy_s;
  assign err_o       = err_r;
  assign stall_cnt_o = stall_cnt_r;

  // Sticky error on any retire that finds no pending write; only reset clears it.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      err_r <= 1'b0;
    end else if (|uf_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Stall-cycle performance counter, wraps naturally; flush does not touch it.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      stall_cnt_r <= {BITSIZE{1'b0}};
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + BITSIZE'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a directed vector table for the
// listed scenarios followed by random traffic checked against a per-register
// pending-write-count model.
module tb_hazard_scoreboard;

`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXI = 3;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1;
    logic        rs1_use;
    logic [4:0]  rs2;
    logic        rs2_use;
    logic [4:0]  rd;
    logic        rd_use;
    logic        issue;
    logic        retire;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        e_stall;
    logic [31:0] e_busy;
    logic        e_err;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        resetn_i;
  logic        ID_chk_valid_i;
  logic [4:0]  ID_chk_rs1_i;
  logic        ID_chk_rs1_use_i;
  logic [4:0]  ID_chk_rs2_i;
  logic        ID_chk_rs2_use_i;
  logic [4:0]  ID_chk_rd_i;
  logic        ID_chk_rd_use_i;
  logic        ID_issue_i;
  logic        WB_retire_i;
  logic [4:0]  WB_retire_rd_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] busy_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  int checks;
  int failures;

  // Reference model: pending-write count per architectural register.
  int          mcnt [32];
  logic        merr;
  logic [31:0] mstall;

  vec_t vecs[$];

  hazard_scoreboard #(.BITSIZE(32), .MAX_INFLIGHT(MAXI)) dut (
    .clk              (clk),
    .resetn_i         (resetn_i),
    .ID_chk_valid_i   (ID_chk_valid_i),
    .ID_chk_rs1_i     (ID_chk_rs1_i),
    .ID_chk_rs1_use_i (ID_chk_rs1_use_i),
    .ID_chk_rs2_i     (ID_chk_rs2_i),
    .ID_chk_rs2_use_i (ID_chk_rs2_use_i),
    .ID_chk_rd_i      (ID_chk_rd_i),
    .ID_chk_rd_use_i  (ID_chk_rd_use_i),
    .ID_issue_i       (ID_issue_i),
    .WB_retire_i      (WB_retire_i),
    .WB_retire_rd_i   (WB_retire_rd_i),
    .flush_i          (flush_i),
    .stall_o          (stall_o),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic ud, input logic iss,
                              input logic ret, input logic [4:0] wrd, input logic fl,
                              input logic es, input logic [31:0] eb, input logic ee,
                              input logic [31:0] ec);
    vec_t t;
    t.valid = v;  t.rs1 = rs1; t.rs1_use = u1; t.rs2 = rs2; t.rs2_use = u2;
    t.rd = rd;    t.rd_use = ud; t.issue = iss; t.retire = ret; t.wb_rd = wrd;
    t.flush = fl; t.e_stall = es; t.e_busy = eb; t.e_err = ee; t.e_cnt = ec;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    ID_chk_valid_i   = t.valid;
    ID_chk_rs1_i     = t.rs1;
    ID_chk_rs1_use_i = t.rs1_use;
    ID_chk_rs2_i     = t.rs2;
    ID_chk_rs2_use_i = t.rs2_use;
    ID_chk_rd_i      = t.rd;
    ID_chk_rd_use_i  = t.rd_use;
    ID_issue_i       = t.issue;
    WB_retire_i      = t.retire;
    WB_retire_rd_i   = t.wb_rd;
    flush_i          = t.flush;
  endtask

  function automatic bit m_raw(input logic [4:0] rs, input logic u);
    bit hit;
    hit = u && (rs != 5'd0) && (mcnt[rs] != 0);
    if (BYP && WB_retire_i && (WB_retire_rd_i == rs) && (mcnt[rs] == 1)) hit = 1'b0;
    return hit;
  endfunction

  function automatic bit m_stall();
    bit ovf;
    ovf = ID_chk_rd_use_i && (ID_chk_rd_i != 5'd0) && (mcnt[ID_chk_rd_i] == MAXI);
    return ID_chk_valid_i &&
           (m_raw(ID_chk_rs1_i, ID_chk_rs1_use_i) || m_raw(ID_chk_rs2_i, ID_chk_rs2_use_i) || ovf);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = 32'd0;
    for (int i = 1; i < 32; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit ir;
    bit dr;
    if (WB_retire_i && (WB_retire_rd_i != 5'd0) && (mcnt[WB_retire_rd_i] == 0)) merr = 1'b1;
    if (m_stall()) mstall = mstall + 32'd1;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      ir = ID_issue_i && ID_chk_rd_use_i && (ID_chk_rd_i != 5'd0);
      dr = WB_retire_i && (WB_retire_rd_i != 5'd0);
      if (!(ir && dr && (ID_chk_rd_i == WB_retire_rd_i))) begin
        if (ir && (mcnt[ID_chk_rd_i] < MAXI)) mcnt[ID_chk_rd_i]++;
        if (dr && (mcnt[WB_retire_rd_i] > 0)) mcnt[WB_retire_rd_i]--;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr   = 1'b0;
    mstall = 32'd0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, m_stall()});
    chk({tag, "_busy"},  busy_o,            m_busy());
    chk({tag, "_err"},   {31'd0, err_o},    {31'd0, merr});
    chk({tag, "_scnt"},  stall_cnt_o,       mstall);
  endtask

  initial begin
    logic [31:0] s2;
    logic [31:0] s3;
    vec_t        idle;
    vec_t        rv;
    checks   = 0;
    failures = 0;
    model_reset();
    idle = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,32'd0,0,32'd0);
    drive(idle);

    // Reset: outputs idle while held and after release.
    resetn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_busy", busy_o, 32'd0);
    chk("rst_hold_err",  {31'd0, err_o}, 32'd0);
    @(negedge clk);
    resetn_i = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_busy",  busy_o, 32'd0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    chk("rst_scnt",  stall_cnt_o, 32'd0);

    // Stall count after the RAW scenario: bypass saves one stall cycle.
    s2 = BYP ? 32'd1 : 32'd2;
    s3 = s2 + 32'd1;

    // v   rs1 u1 rs2 u2  rd ud iss ret wrd fl | stall busy        err cnt
    vecs.push_back(mk(0, 0,0, 0,0,  0,0,0, 1,0,0, 0,32'd0,0,32'd0));          // retire x0: no error
    vecs.push_back(mk(1, 0,0, 0,0,  5,1,1, 0,0,0, 0,32'd0,0,32'd0));          // issue rd=5
    vecs.push_back(mk(1, 5,1, 0,0,  0,0,0, 0,0,0, 1,32'h20,0,32'd0));         // RAW rs1=5
    vecs.push_back(mk(1, 0,0, 5,1,  0,0,0, 1,5,0, !BYP,32'h20,0,32'd1));      // RAW rs2=5 during WB
    vecs.push_back(mk(1, 0,0, 5,1,  0,0,0, 0,0,0, 0,32'd0,0,s2));             // freed after WB
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0,1, 0,1, 0,1,1, 0,0,0, 0,32'd0,0,s2));            // issue x0, read x0
    vecs.push_back(mk(1, 0,0, 0,0,  7,1,1, 0,0,0, 0,32'd0,0,s2));             // issue rd=7 #1
    vecs.push_back(mk(1, 0,0, 0,0,  7,1,1, 0,0,0, 0,32'h80,0,s2));            // #2
    vecs.push_back(mk(1, 0,0, 0,0,  7,1,1, 0,0,0, 0,32'h80,0,s2));            // #3
    vecs.push_back(mk(1, 0,0, 0,0,  7,1,0, 0,0,0, 1,32'h80,0,s2));            // overflow stall
    vecs.push_back(mk(0, 0,0, 0,0,  7,1,0, 0,0,0, 0,32'h80,0,s3));            // not valid: no stall
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0,0, 0,0, 0,0,0, 1,7,0, 0,32'h80,0,s3));           // drain rd=7
    vecs.push_back(mk(1, 0,0, 0,0,  3,1,1, 0,0,0, 0,32'd0,0,s3));             // issue rd=3
    vecs.push_back(mk(1, 0,0, 0,0,  3,1,1, 1,3,0, 0,32'h8,0,s3));             // issue+retire rd=3
    vecs.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,0, 0,32'h8,0,s3));             // still one pending
    vecs.push_back(mk(0, 0,0, 0,0,  0,0,0, 1,3,0, 0,32'h8,0,s3));             // retire rd=3
    vecs.push_back(mk(0, 0,0, 0,0,  0,0,0, 1,9,0, 0,32'd0,0,s3));             // retire idle rd=9
    vecs.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,0, 0,32'd0,1,s3));             // err set
    vecs.push_back(mk(0, 0,0, 0,0,  0,0,0, 0,0,0, 0,32'd0,1,s3));             // err sticky
    vecs.push_back(mk(1, 0,0, 0,0,  4,1,1, 0,0,0, 0,32'd0,1,s3));             // issue rd=4
    vecs.push_back(mk(1, 0,0, 0,0,  6,1,1, 0,0,0, 0,32'h10,1,s3));            // issue rd=6
    vecs.push_back(mk(1, 0,0, 0,0,  8,1,1, 0,0,1, 0,32'h50,1,s3));            // issue rd=8 + flush
    vecs.push_back(mk(1, 8,1, 4,1,  6,1,0, 0,0,0, 0,32'd0,1,s3));             // all cleared

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_busy", i),  busy_o,            vecs[i].e_busy);
      chk($sformatf("v%0d_err", i),   {31'd0, err_o},    {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_scnt", i),  stall_cnt_o,       vecs[i].e_cnt);
      model_step();
    end

    // Random traffic on a small register window so hazards collide often.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rv = idle;
      rv.valid   = ($urandom_range(3) != 0);
      rv.rs1     = 5'($urandom_range(7));
      rv.rs1_use = 1'($urandom_range(1));
      rv.rs2     = 5'($urandom_range(7));
      rv.rs2_use = 1'($urandom_range(1));
      rv.rd      = 5'($urandom_range(7));
      rv.rd_use  = 1'($urandom_range(1));
      rv.retire  = ($urandom_range(9) < 4);
      rv.wb_rd   = 5'($urandom_range(7));
      rv.flush   = ($urandom_range(39) == 0);
      drive(rv);
      #0;
      ID_issue_i = ID_chk_valid_i && (m_stall() ? ($urandom_range(7) == 0) : ($urandom_range(1) == 1));
      #1;
      check_model("rnd");
      model_step();
    end

    // Asynchronous reset mid-cycle clears state without a clock edge.
    @(negedge clk);
    drive(mk(1, 1,1, 2,1, 3,1,1, 1,4,0, 0,32'd0,0,32'd0));
    #2;
    resetn_i = 1'b0;
    #1;
    chk("async_busy",  busy_o, 32'd0);
    chk("async_err",   {31'd0, err_o}, 32'd0);
    chk("async_scnt",  stall_cnt_o, 32'd0);
    chk("async_stall", {31'd0, stall_o}, 32'd0);
    model_reset();
    drive(idle);
    @(negedge clk);
    resetn_i = 1'b1;

    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rv = idle;
      rv.valid   = 1'b1;
      rv.rs1     = 5'($urandom_range(3));
      rv.rs1_use = 1'b1;
      rv.rd      = 5'($urandom_range(3));
      rv.rd_use  = 1'b1;
      rv.retire  = 1'($urandom_range(1));
      rv.wb_rd   = 5'($urandom_range(3));
      drive(rv);
      #0;
      ID_issue_i = !m_stall();
      #1;
      check_model("post");
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
